fdivsqrt_seq_ctrl: RTL and testbench

FDIVSQRT_SEQ_CTRL -- requirements
Module: fdivsqrt_seq_ctrl

---
 rtl/fdivsqrt_pkg.sv | 18 +
 rtl/fdivsqrt_step_cnt.sv | 39 +++
 rtl/fdivsqrt_seq_ctrl.sv | 87 ++++++++
 tb/tb_fdivsqrt_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdivsqrt_pkg.sv
// Shared configuration and types for the divide/sqrt sequencer.
// Holds the datapath sizing constants and the FSM state enum.
package fdivsqrt_pkg;

  localparam int FDS_XLEN = 64;
  // Quotient bits retired per iteration step.
  localparam int FDS_RK = 2;
  // Worst-case iterations plus pre/post-normalisation slack.
  localparam int FDS_MAXCYC = FDS_XLEN / FDS_RK + 2;
  localparam int FDS_DURLEN = $clog2(FDS_MAXCYC + 1);

  typedef enum logic [1:0] {
    FDS_IDLE = 2'd0,
    FDS_BUSY = 2'd1,
    FDS_DONE = 2'd2
  } fds_state_e;

endpackage

// File: rtl/fdivsqrt_step_cnt.sv
// Loadable down-counter tracking remaining iteration steps.
// Ports: clk, reset (async), clr_i, ld_i, dec_i, ld_val_i, one_o.
module fdivsqrt_step_cnt
  import fdivsqrt_pkg::*;
#(
  parameter int W = FDS_DURLEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic         dec_i,
  input  logic [W-1:0] ld_val_i,
  output logic         one_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Decrement saturates at 1 so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (ld_i)
      cnt_d = ld_val_i;
    else if (dec_i && (cnt_q > W'(1)))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign one_o = (cnt_q == W'(1));

endmodule

// File: rtl/fdivsqrt_seq_ctrl.sv
// Sequencer for the iterative FP/integer divide-sqrt unit.
// Ports: start/special/cycle inputs, StallM/FlushE; accept, busy, iterate, done, SpecialCaseM.
module fdivsqrt_seq_ctrl
  import fdivsqrt_pkg::*;
#(
  parameter int DURLEN = FDS_DURLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FDivStartE,
  input  logic              IDivStartE,
  input  logic              IntDivE,
  input  logic              FSpecialCaseE,
  input  logic              ISpecialCaseE,
  input  logic [DURLEN-1:0] CyclesE,
  input  logic              StallM,
  input  logic              FlushE,
  output logic              IFDivStartE,
  output logic              FDivBusyE,
  output logic              IterEnE,
  output logic              FDivDoneE,
  output logic              SpecialCaseM
);

  fds_state_e        state_q;
  logic              SpecialCaseE;
  logic              st_idle, st_busy, st_done;
  logic              cnt_one;
  logic [DURLEN-1:0] ld_val;

  assign st_idle = (state_q == FDS_IDLE);
  assign st_busy = (state_q == FDS_BUSY);
  assign st_done = (state_q == FDS_DONE);

  assign SpecialCaseE = IntDivE ? ISpecialCaseE : FSpecialCaseE;

  // Gated by reset so no accept pulse escapes while reset is held.
  assign IFDivStartE = (FDivStartE | IDivStartE) & st_idle
                     & ~FlushE & ~reset;

  assign IterEnE   = st_busy;
  assign FDivDoneE = st_done;
  assign FDivBusyE = st_busy | (st_done & StallM);

  // A zero cycle count still needs one iteration step.
  assign ld_val = (CyclesE == '0) ? DURLEN'(1) : CyclesE;

  fdivsqrt_step_cnt #(
    .W (DURLEN)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (FlushE),
    .ld_i     (IFDivStartE & ~SpecialCaseE),
    .dec_i    (st_busy),
    .ld_val_i (ld_val),
    .one_o    (cnt_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FDS_IDLE;
      SpecialCaseM <= 1'b0;
    end else begin
      if (IFDivStartE)
        SpecialCaseM <= SpecialCaseE;
      if (FlushE) begin
        state_q <= FDS_IDLE;
      end else begin
        unique case (state_q)
          FDS_IDLE:
            if (IFDivStartE)
              state_q <= SpecialCaseE ? FDS_DONE : FDS_BUSY;
          FDS_BUSY:
            if (cnt_one)
              state_q <= FDS_DONE;
          FDS_DONE:
            if (!StallM)
              state_q <= FDS_IDLE;
          default:
            state_q <= FDS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fdivsqrt_seq_ctrl.sv
// Self-checking bench for fdivsqrt_seq_ctrl.
// Directed timing scenarios plus random traffic against a schedule model.
module tb_fdivsqrt_seq_ctrl;
  import fdivsqrt_pkg::*;

  localparam int DL = FDS_DURLEN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          FDivStartE = 1'b0;
  logic          IDivStartE = 1'b0;
  logic          IntDivE = 1'b0;
  logic          FSpecialCaseE = 1'b0;
  logic          ISpecialCaseE = 1'b0;
  logic [DL-1:0] CyclesE = '0;
  logic          StallM = 1'b0;
  logic          FlushE = 1'b0;
  logic          IFDivStartE, FDivBusyE, IterEnE, FDivDoneE, SpecialCaseM;

  fdivsqrt_seq_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .FDivStartE    (FDivStartE),
    .IDivStartE    (IDivStartE),
    .IntDivE       (IntDivE),
    .FSpecialCaseE (FSpecialCaseE),
    .ISpecialCaseE (ISpecialCaseE),
    .CyclesE       (CyclesE),
    .StallM        (StallM),
    .FlushE        (FlushE),
    .IFDivStartE   (IFDivStartE),
    .FDivBusyE     (FDivBusyE),
    .IterEnE       (IterEnE),
    .FDivDoneE     (FDivDoneE),
    .SpecialCaseM  (SpecialCaseM)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int iter_seen = 0;
  int done_seen = 0;

  // Model: one op in flight, accepted at cycle m_acc, iterating
  // for m_nb cycles after that, then done until taken.
  bit m_act = 1'b0;
  int m_acc = 0;
  int m_nb = 0;
  bit m_spec = 1'b0;
  bit e_start, e_busy, e_iter, e_done;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d",
             tag, o, e, cyc);
    end
  endtask

  task automatic model_eval();
    int rel;
    e_start = 1'b0;
    e_busy = 1'b0;
    e_iter = 1'b0;
    e_done = 1'b0;
    if (!m_act) begin
      e_start = (FDivStartE | IDivStartE) & ~FlushE;
    end else begin
      rel = cyc - m_acc;
      if (rel <= m_nb) begin
        e_iter = 1'b1;
        e_busy = 1'b1;
      end else begin
        e_done = 1'b1;
        e_busy = StallM;
      end
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0;
    m_spec = 1'b0;
  endtask

  task automatic tick(string tag);
    bit sp;
    int n;
    @(negedge clk);
    model_eval();
    chk({tag, ".start"}, 32'(IFDivStartE), 32'(e_start));
    chk({tag, ".busy"}, 32'(FDivBusyE), 32'(e_busy));
    chk({tag, ".iter"}, 32'(IterEnE), 32'(e_iter));
    chk({tag, ".done"}, 32'(FDivDoneE), 32'(e_done));
    chk({tag, ".specm"}, 32'(SpecialCaseM), 32'(m_spec));
    chk({tag, ".excl"}, 32'(IterEnE & FDivDoneE), 32'd0);
    if (IterEnE === 1'b1) iter_seen++;
    if (FDivDoneE === 1'b1) done_seen++;
    @(posedge clk);
    sp = IntDivE ? ISpecialCaseE : FSpecialCaseE;
    n = (int'(CyclesE) == 0) ? 1 : int'(CyclesE);
    if (FlushE) begin
      m_act = 1'b0;
    end else if (!m_act && e_start) begin
      m_act = 1'b1;
      m_acc = cyc;
      m_nb = sp ? 0 : n;
      m_spec = sp;
    end else if (m_act && e_done && !StallM) begin
      m_act = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic drv(bit fd, bit id, bit intd, bit fs, bit is,
                     int c, bit st, bit fl);
    FDivStartE = fd;
    IDivStartE = id;
    IntDivE = intd;
    FSpecialCaseE = fs;
    ISpecialCaseE = is;
    CyclesE = DL'(c);
    StallM = st;
    FlushE = fl;
  endtask

  task automatic idle_in();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset pulse asserted mid-cycle; outputs must drop at once.
  task automatic rst_pulse(string tag);
    FDivStartE = 1'b1;
    reset = 1'b1;
    #1;
    chk({tag, ".rst_start"}, 32'(IFDivStartE), 32'd0);
    chk({tag, ".rst_busy"}, 32'(FDivBusyE), 32'd0);
    chk({tag, ".rst_iter"}, 32'(IterEnE), 32'd0);
    chk({tag, ".rst_done"}, 32'(FDivDoneE), 32'd0);
    chk({tag, ".rst_specm"}, 32'(SpecialCaseM), 32'd0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    FDivStartE = 1'b0;
  endtask

  initial begin
    FDivStartE = 1'b1;
    #1;
    chk("por.start", 32'(IFDivStartE), 32'd0);
    chk("por.busy", 32'(FDivBusyE), 32'd0);
    chk("por.iter", 32'(IterEnE), 32'd0);
    chk("por.done", 32'(FDivDoneE), 32'd0);
    chk("por.specm", 32'(SpecialCaseM), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_in();
    tick("idle");

    // FP op, 5 steps
    iter_seen = 0;
    done_seen = 0;
    drv(1, 0, 0, 0, 0, 5, 0, 0);
    tick("c5");
    idle_in();
    repeat (7) tick("c5");
    chk("c5.iter_cnt", 32'(iter_seen), 32'd5);
    chk("c5.done_cnt", 32'(done_seen), 32'd1);

    // Integer special case: straight to done
    iter_seen = 0;
    done_seen = 0;
    drv(0, 1, 1, 0, 1, 9, 0, 0);
    tick("isp");
    idle_in();
    repeat (3) tick("isp");
    chk("isp.iter_cnt", 32'(iter_seen), 32'd0);
    chk("isp.done_cnt", 32'(done_seen), 32'd1);
    chk("isp.specm_hold", 32'(SpecialCaseM), 32'd1);

    // Zero cycle count still iterates once
    iter_seen = 0;
    done_seen = 0;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick("c0");
    idle_in();
    repeat (4) tick("c0");
    chk("c0.iter_cnt", 32'(iter_seen), 32'd1);
    chk("c0.specm_clr", 32'(SpecialCaseM), 32'd0);

    // Result held in done while memory stalls
    iter_seen = 0;
    done_seen = 0;
    drv(1, 0, 0, 0, 0, 4, 0, 0);
    tick("stall");
    idle_in();
    repeat (2) tick("stall");
    StallM = 1'b1;
    repeat (6) tick("stall");
    StallM = 1'b0;
    repeat (3) tick("stall");
    chk("stall.iter_cnt", 32'(iter_seen), 32'd4);
    chk("stall.done_cnt", 32'(done_seen), 32'd5);

    // Flush mid-iteration, then immediate new start
    done_seen = 0;
    drv(1, 0, 0, 0, 0, 8, 0, 0);
    tick("flush");
    idle_in();
    repeat (2) tick("flush");
    drv(1, 0, 0, 0, 0, 8, 0, 1);
    tick("flush");
    chk("flush.no_done", 32'(done_seen), 32'd0);
    drv(1, 0, 0, 0, 0, 2, 0, 0);
    tick("flush_re");
    idle_in();
    repeat (5) tick("flush_re");
    chk("flush_re.done_cnt", 32'(done_seen), 32'd1);

    // Reset mid-operation abandons it
    done_seen = 0;
    iter_seen = 0;
    drv(1, 0, 0, 0, 0, 8, 0, 0);
    tick("rst");
    idle_in();
    tick("rst");
    rst_pulse("rst");
    idle_in();
    repeat (3) tick("rst");
    chk("rst.no_done", 32'(done_seen), 32'd0);
    drv(0, 0, 0, 1, 0, 3, 0, 0);
    FDivStartE = 1'b1;
    tick("rst_re");
    idle_in();
    repeat (3) tick("rst_re");
    chk("rst_re.iter_cnt", 32'(iter_seen), 32'd1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      FDivStartE = ($urandom_range(0, 2) == 0);
      IDivStartE = ($urandom_range(0, 3) == 0);
      IntDivE = $urandom_range(0, 1) == 1;
      FSpecialCaseE = ($urandom_range(0, 4) == 0);
      ISpecialCaseE = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0)
        CyclesE = DL'($urandom_range(0, (1 << DL) - 1));
      else
        CyclesE = DL'($urandom_range(0, 6));
      StallM = ($urandom_range(0, 2) == 0);
      FlushE = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0)
        rst_pulse("rnd");
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
